pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder.sv | 162 ++++++++++++++++
 tb/tb_pwm_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM duty decoder: measures high/low time of each frame on an asynchronous line and
// reports the 4-bit duty. Optional glitch filter enabled by PWM_DEC_GLITCH_FILTER_EN.
module pwm_decoder #(
  parameter int STEP_LOG2 = 0,
  parameter int TOL       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [3:0] duty,
  output logic       valid,
  output logic       frame_err
);

  localparam int FRAME   = 16 << STEP_LOG2;
  localparam int TIMEOUT = 2 * FRAME;
  localparam logic [16:0] FRAME_W   = 17'(FRAME);
  localparam logic [16:0] TOL_W     = 17'(TOL);
  localparam logic [15:0] QUIET_MAX = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [1:0]  sync_reg;
  logic        level;
  logic        level_prev_reg;
  logic        rise;
  logic        fall;
  logic        edge_seen;

  state_t      state_reg, state_next;
  logic [15:0] hi_cnt_reg, hi_cnt_next;
  logic [15:0] lo_cnt_reg, lo_cnt_next;
  logic [15:0] quiet_cnt_reg, quiet_cnt_next;
  logic [3:0]  duty_reg, duty_next;
  logic        valid_reg, valid_next;
  logic        frame_err_reg, frame_err_next;

  logic [16:0] period;
  logic [16:0] deviation;
  logic [15:0] steps;
  logic        in_tol;
  logic        timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg       <= 2'b00;
      level_prev_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], pwm_in};
      level_prev_reg <= level;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  // Level follows the synchronizer only once three successive samples agree.
  logic [1:0] hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_reg <= 2'b00;
    else      hist_reg <= {hist_reg[0], sync_reg[1]};
  end

  assign level = (sync_reg[1] == hist_reg[0] && hist_reg[0] == hist_reg[1])
                 ? sync_reg[1] : level_prev_reg;
`else
  assign level = sync_reg[1];
`endif

  assign rise      = level & ~level_prev_reg;
  assign fall      = ~level & level_prev_reg;
  assign edge_seen = rise | fall;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign period    = {1'b0, hi_cnt_reg} + {1'b0, lo_cnt_reg};
  assign deviation = (period > FRAME_W) ? period - FRAME_W : FRAME_W - period;
  assign in_tol    = (deviation <= TOL_W);
  assign steps     = hi_cnt_reg >> STEP_LOG2;
  assign timeout   = !edge_seen && (quiet_cnt_reg == QUIET_MAX);

  always_comb begin
    state_next     = state_reg;
    hi_cnt_next    = hi_cnt_reg;
    lo_cnt_next    = lo_cnt_reg;
    quiet_cnt_next = edge_seen ? 16'd0 : sat_inc(quiet_cnt_reg);
    duty_next      = duty_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    if (timeout) begin
      // Line stuck: report its level as 0 % or 100 % and restart from IDLE.
      state_next     = IDLE;
      hi_cnt_next    = 16'd0;
      lo_cnt_next    = 16'd0;
      quiet_cnt_next = 16'd0;
      duty_next      = level ? 4'hF : 4'h0;
      valid_next     = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (rise) begin
            state_next  = HIGH;
            hi_cnt_next = 16'd1;
            lo_cnt_next = 16'd0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next  = LOW;
            lo_cnt_next = sat_inc(lo_cnt_reg);
          end else begin
            hi_cnt_next = sat_inc(hi_cnt_reg);
          end
        end
        LOW: begin
          if (rise) begin
            // The closing rise is also the first high cycle of the next frame.
            state_next  = HIGH;
            hi_cnt_next = 16'd1;
            lo_cnt_next = 16'd0;
            if (in_tol) begin
              duty_next  = (steps > 16'd15) ? 4'hF : steps[3:0];
              valid_next = 1'b1;
            end else begin
              frame_err_next = 1'b1;
            end
          end else begin
            lo_cnt_next = sat_inc(lo_cnt_reg);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      hi_cnt_reg    <= 16'd0;
      lo_cnt_reg    <= 16'd0;
      quiet_cnt_reg <= 16'd0;
      duty_reg      <= 4'h0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hi_cnt_reg    <= hi_cnt_next;
      lo_cnt_reg    <= lo_cnt_next;
      quiet_cnt_reg <= quiet_cnt_next;
      duty_reg      <= duty_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign duty      = duty_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder (STEP_LOG2=0, TOL=0, FRAME=16).
module tb_pwm_decoder;

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam int HI_B = 13;
`else
  localparam int LAT  = 3;
  localparam int HI_B = 15;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] duty;
  logic       valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int both_cnt = 0;
  int first_valid_cyc = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int frame_start = 0;
  int fall_cyc = 0;

  pwm_decoder #(.STEP_LOG2(0), .TOL(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-18s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_cycle(input logic v);
    @(posedge clk);
    #1 pwm_in = v;
    @(negedge clk);
    cyc++;
    if (valid) begin
      if (n_valid == 0) first_valid_cyc = cyc;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      n_valid++;
    end
    if (frame_err) n_err++;
    if (valid && frame_err) both_cnt++;
  endtask

  task automatic frame(input int hi, input int lo);
    frame_start = cyc + 1;
    repeat (hi) drive_cycle(1'b1);
    repeat (lo) drive_cycle(1'b0);
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_err = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_duty", 32'(duty), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(frame_err), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive_cycle(1'b0);
    drive_cycle(1'b0);

    // Steady 6/10 stream
    clear_counts();
    frame(6, 10);
    check("a_first_edge", 32'(n_valid), 0);
    frame(6, 10);
    frame(6, 10);
    frame(6, 10);
    check("a_valid_cnt", 32'(n_valid), 3);
    check("a_duty", 32'(duty), 6);
    check("a_err_cnt", 32'(n_err), 0);
    check("a_spacing", 32'(last_valid_cyc - prev_valid_cyc), 16);
    check("a_latency", 32'(last_valid_cyc - frame_start), LAT);

    // Near-full duty, then the line stuck low
    repeat (3) frame(HI_B, 16 - HI_B);
    repeat (HI_B) drive_cycle(1'b1);
    check("b_duty_hi", 32'(duty), HI_B);
    clear_counts();
    fall_cyc = cyc + 1;
    repeat (70) drive_cycle(1'b0);
    check("b_timeout_cnt", 32'(n_valid), 2);
    check("b_duty_zero", 32'(duty), 0);
    check("b_timeout_at", 32'(first_valid_cyc - fall_cyc), LAT + 32);
    check("b_repeat", 32'(last_valid_cyc - first_valid_cyc), 32);
    check("b_err_cnt", 32'(n_err), 0);

    // Off-period frame rejected
    frame(6, 10);
    frame(6, 10);
    frame(8, 12);
    check("c_duty_locked", 32'(duty), 6);
    clear_counts();
    frame(11, 5);
    check("c_err_cnt", 32'(n_err), 1);
    check("c_no_valid", 32'(n_valid), 0);
    check("c_duty_held", 32'(duty), 6);
    frame(6, 10);
    check("c_recover_duty", 32'(duty), 11);
    check("c_recover_cnt", 32'(n_valid), 1);

    // Reset in the middle of a high phase
    frame(9, 7);
    frame(9, 7);
    check("d_duty_pre", 32'(duty), 9);
    repeat (4) drive_cycle(1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("d_rst_duty", 32'(duty), 0);
    check("d_rst_valid", 32'(valid), 0);
    repeat (5) drive_cycle(1'b1);
    repeat (2) drive_cycle(1'b0);
    rst = 1'b1;
    repeat (5) drive_cycle(1'b0);
    clear_counts();
    frame(9, 7);
    check("d_first_edge", 32'(n_valid), 0);
    check("d_first_err", 32'(n_err), 0);
    frame(9, 7);
    check("d_duty_post", 32'(duty), 9);
    check("d_valid_cnt", 32'(n_valid), 1);

    // One-cycle glitch inside the low phase
    frame(6, 10);
    frame(6, 10);
    check("e_duty_pre", 32'(duty), 6);
    clear_counts();
    repeat (6) drive_cycle(1'b1);
    repeat (4) drive_cycle(1'b0);
    drive_cycle(1'b1);
    repeat (5) drive_cycle(1'b0);
    frame(6, 10);
    frame(6, 10);
    check("e_duty", 32'(duty), 6);
`ifdef PWM_DEC_GLITCH_FILTER_EN
    check("e_err_cnt", 32'(n_err), 0);
    check("e_valid_cnt", 32'(n_valid), 3);
`else
    check("e_err_cnt", 32'(n_err), 2);
    check("e_valid_cnt", 32'(n_valid), 2);
`endif

    check("valid_and_err", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
